// File: rtl/pulse_width_pkg.sv
// Shared definitions for the pulse-width link: FSM states and the pulse-length
// multipliers that both the transmitter and receiver sides agree on.
package pulse_width_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } pw_state_e;

  // Pulse lengths as multiples of the base time unit NUM.
  localparam int unsigned LONG_MULT  = 4;
  localparam int unsigned SHORT_MULT = 1;
  localparam int unsigned GAP_MULT   = 1;

  // Receiver decision threshold and timer wrap point, in units of NUM.
  localparam int unsigned RX_THRESH_MULT = 3;
  localparam int unsigned RX_WRAP_MULT   = 6;

  // Phase counter must hold the longest pulse length.
  function automatic int unsigned pw_cnt_width(input int unsigned num);
    return $clog2(LONG_MULT * num + 1);
  endfunction

endpackage

// File: rtl/pulse_width_tx_if.sv
// Word handshake and serial line bundle between a word source and pulse_width_tx.
interface pulse_width_tx_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] data_in;
  logic             valid;
  logic             ready;
  logic             line;
  logic             busy;
  logic             done;

  modport master (
    output data_in,
    output valid,
    input  ready,
    input  line,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  valid,
    output ready,
    output line,
    output busy,
    output done
  );

endinterface

// File: rtl/pw_phase_counter.sv
// Loadable down-counter timing one pulse or gap; last_o flags the final cycle.
module pw_phase_counter #(
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             last_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == Width'(1));

endmodule

// File: rtl/pulse_width_tx.sv
// Pulse-width serial transmitter: shifts a word out MSB-first as one high pulse
// per bit (long for 1, short for 0) followed by a fixed low gap.
module pulse_width_tx
  import pulse_width_pkg::*;
#(
  parameter int unsigned NUM   = 4,
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  pulse_width_tx_if.slave bus
);

  localparam int unsigned CntW = pw_cnt_width(NUM);
  localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CntW-1:0] LongLen  = CntW'(LONG_MULT * NUM);
  localparam logic [CntW-1:0] ShortLen = CntW'(SHORT_MULT * NUM);
  localparam logic [CntW-1:0] GapLen   = CntW'(GAP_MULT * NUM);

  if (NUM < 2) begin : gen_bad_num
    $error("pulse_width_tx: NUM must be at least 2");
  end
  if (WIDTH < 1) begin : gen_bad_width
    $error("pulse_width_tx: WIDTH must be at least 1");
  end
  if (LONG_MULT >= RX_WRAP_MULT) begin : gen_bad_wrap
    $error("pulse_width_tx: long pulse would wrap the receiver timer");
  end
  if (LONG_MULT - 1 < RX_THRESH_MULT) begin : gen_bad_thresh
    $error("pulse_width_tx: long pulse too short for the receiver threshold");
  end

  pw_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             line_q, line_d;
  logic             done_q, done_d;
  logic             cnt_load;
  logic [CntW-1:0]  cnt_load_val;
  logic             cnt_last;

  function automatic logic [CntW-1:0] high_len(input logic b);
    return b ? LongLen : ShortLen;
  endfunction

  pw_phase_counter #(
    .Width(CntW)
  ) u_phase_counter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .last_o    (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.valid) begin
          shift_d      = bus.data_in;
          bit_cnt_d    = BitW'(WIDTH - 1);
          cnt_load     = 1'b1;
          cnt_load_val = high_len(bus.data_in[WIDTH-1]);
          state_d      = StHigh;
        end
      end
      StHigh: begin
        if (cnt_last) begin
          cnt_load     = 1'b1;
          cnt_load_val = GapLen;
          state_d      = StLow;
        end
      end
      StLow: begin
        if (cnt_last) begin
          if (bit_cnt_q != '0) begin
            shift_d      = shift_q << 1;
            bit_cnt_d    = bit_cnt_q - BitW'(1);
            cnt_load     = 1'b1;
            cnt_load_val = high_len(shift_d[WIDTH-1]);
            state_d      = StHigh;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line is registered so it changes on the same edge as the state.
    line_d = (state_d == StHigh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      line_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      line_q    <= line_d;
      done_q    <= done_d;
    end
  end

  assign bus.ready = (state_q == StIdle);
  assign bus.busy  = (state_q != StIdle);
  assign bus.line  = line_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_pulse_width_tx.sv
// Directed bench for pulse_width_tx: measures line run lengths, decodes them the
// way the receiver would, and checks timing against hand-computed values.
module tb_pulse_width_tx;
  import pulse_width_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pulse_width_tx_if #(.WIDTH(8)) bus_a ();
  pulse_width_tx_if #(.WIDTH(1)) bus_b ();

  pulse_width_tx #(.NUM(4), .WIDTH(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  pulse_width_tx #(.NUM(2), .WIDTH(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int checks = 0;
  int failures = 0;

  int hi_len[8];
  int lo_len[8];
  int npulse, first_rise, done_at, ndone, ready_bad, excl_bad, line_after_rst;
  logic [7:0] decoded;
  int a5_hi[8] = '{16, 4, 16, 4, 4, 16, 4, 16};

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Follow one word cycle by cycle until done or the budget runs out.
  task automatic watch(input bit sel, input int budget, input int inj_at, input int rst_at,
                       input bit chain, input logic [7:0] next_w);
    int   cur_hi, cur_lo, thresh;
    logic ln, dn, rd, bz;
    thresh = RX_THRESH_MULT * (sel ? 2 : 4);
    npulse = 0; cur_hi = 0; cur_lo = 0; first_rise = -1; done_at = -1; ndone = 0;
    ready_bad = 0; excl_bad = 0; decoded = '0; line_after_rst = -1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      tick();
      rst = (cyc == rst_at);
      if (!sel) begin
        bus_a.valid = (cyc == inj_at);
        if (cyc == inj_at) bus_a.data_in = 8'h3C;
      end else begin
        bus_b.valid = 1'b0;
      end
      ln = sel ? bus_b.line  : bus_a.line;
      dn = sel ? bus_b.done  : bus_a.done;
      rd = sel ? bus_b.ready : bus_a.ready;
      bz = sel ? bus_b.busy  : bus_a.busy;
      if (rst_at > 0 && cyc == rst_at + 1) line_after_rst = int'(ln);
      if (rd === bz) excl_bad++;
      if (dn) begin
        ndone++;
        done_at = cyc;
        if (npulse > 0 && npulse <= 8) lo_len[npulse-1] = cur_lo;
        if (chain) begin
          bus_a.valid   = 1'b1;
          bus_a.data_in = next_w;
        end
        break;
      end
      if (rd && first_rise >= 0) ready_bad++;
      if (ln) begin
        if (cur_lo > 0 && npulse > 0 && npulse <= 8) lo_len[npulse-1] = cur_lo;
        cur_lo = 0;
        cur_hi++;
        if (first_rise < 0) first_rise = cyc;
      end else if (cur_hi > 0) begin
        if (npulse < 8) hi_len[npulse] = cur_hi;
        decoded = {decoded[6:0], (cur_hi >= thresh)};
        npulse++;
        cur_hi = 0;
        cur_lo = 1;
      end else if (npulse > 0) begin
        cur_lo++;
      end
    end
  endtask

  initial begin
    int bad, hi_after;
    rst = 1'b1;
    bus_a.valid = 1'b0; bus_a.data_in = '0;
    bus_b.valid = 1'b0; bus_b.data_in = '0;

    // Reset with valid asserted: must not be accepted.
    bus_a.valid = 1'b1; bus_a.data_in = 8'hFF;
    repeat (3) tick();
    bus_a.valid = 1'b0;
    rst = 1'b0;
    tick();
    check1("rst_line", bus_a.line, 1'b0);
    check1("rst_ready", bus_a.ready, 1'b1);
    check1("rst_busy", bus_a.busy, 1'b0);
    check1("rst_done", bus_a.done, 1'b0);
    check1("rst_ready_b", bus_b.ready, 1'b1);

    // Mixed word 8'hA5.
    bus_a.data_in = 8'hA5; bus_a.valid = 1'b1;
    watch(1'b0, 400, 0, 0, 1'b0, 8'h00);
    check("a5_pulses", npulse, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("a5_hi%0d", i), hi_len[i], a5_hi[i]);
      check($sformatf("a5_lo%0d", i), lo_len[i], 4);
    end
    check("a5_first_rise", first_rise, 1);
    check("a5_duration", done_at - first_rise, 112);
    check("a5_decoded", int'(decoded), 32'hA5);
    check("a5_ready_mid", ready_bad, 0);
    check("a5_ready_busy_excl", excl_bad, 0);
    check1("a5_done_ready", bus_a.ready, 1'b1);
    tick();
    check1("a5_done_one_cycle", bus_a.done, 1'b0);

    // Back-to-back 8'hFF then 8'h00, second accepted in the done cycle.
    bus_a.data_in = 8'hFF; bus_a.valid = 1'b1;
    watch(1'b0, 400, 0, 0, 1'b1, 8'h00);
    bad = 0;
    for (int i = 0; i < 8; i++) if (hi_len[i] != 16) bad++;
    check("ff_pulses", npulse, 8);
    check("ff_long_all", bad, 0);
    check("ff_decoded", int'(decoded), 32'hFF);
    check("ff_duration", done_at - first_rise, 160);
    check("ff_ready_mid", ready_bad, 0);
    watch(1'b0, 400, 0, 0, 1'b0, 8'h00);
    check("b2b_rise_after_gap", first_rise, 1);
    check("zz_pulses", npulse, 8);
    check("zz_decoded", int'(decoded), 0);
    check("zz_duration", done_at - first_rise, 64);
    check("zz_ready_mid", ready_bad, 0);
    tick();

    // valid with 8'h3C while busy is ignored.
    bus_a.data_in = 8'hA5; bus_a.valid = 1'b1;
    watch(1'b0, 400, 20, 0, 1'b0, 8'h00);
    check("busy_pulses", npulse, 8);
    check("busy_decoded", int'(decoded), 32'hA5);
    check("busy_duration", done_at - first_rise, 112);
    hi_after = 0;
    repeat (12) begin
      tick();
      if (bus_a.line !== 1'b0) hi_after++;
    end
    check("busy_word_dropped", hi_after, 0);

    // Reset during the third HIGH phase (cycles 29..44 of the word).
    bus_a.data_in = 8'hA5; bus_a.valid = 1'b1;
    watch(1'b0, 60, 0, 35, 1'b0, 8'h00);
    check("mid_rst_line", line_after_rst, 0);
    check("mid_rst_no_done", ndone, 0);
    check1("mid_rst_ready", bus_a.ready, 1'b1);
    check1("mid_rst_busy", bus_a.busy, 1'b0);
    bus_a.data_in = 8'h81; bus_a.valid = 1'b1;
    watch(1'b0, 400, 0, 0, 1'b0, 8'h00);
    check("w81_pulses", npulse, 8);
    check("w81_decoded", int'(decoded), 32'h81);
    check("w81_hi0", hi_len[0], 16);
    check("w81_hi1", hi_len[1], 4);
    check("w81_hi7", hi_len[7], 16);
    check("w81_duration", done_at - first_rise, 88);
    tick();

    // Minimum parameters: NUM=2, WIDTH=1, data=1.
    bus_b.data_in = 1'b1; bus_b.valid = 1'b1;
    watch(1'b1, 100, 0, 0, 1'b0, 8'h00);
    check("min_pulses", npulse, 1);
    check("min_hi", hi_len[0], 8);
    check("min_lo", lo_len[0], 2);
    check("min_first_rise", first_rise, 1);
    check("min_duration", done_at - first_rise, 10);
    check("min_decoded", int'(decoded), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
